// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - modulo-MOD up/down counter with load, terminal count and wrap pulse
// Define UPDN_CNT_SAT_EN to saturate at 0 / MOD-1 instead of wrapping around.
module param_updown_counter #(
   parameter int WIDTH = 4,
   parameter int MOD   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             dir_q
);

   // One spare bit so MOD-1 and din compare safely when MOD == 2**WIDTH.
   localparam logic [WIDTH:0]   MAX_CNT = (WIDTH+1)'(MOD - 1);
   localparam logic [WIDTH-1:0] MAX_Q   = MAX_CNT[WIDTH-1:0];

   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   din_ext;
   logic             at_top;
   logic             at_bot;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q_step;

   assign q_ext   = {1'b0, q};
   assign din_ext = {1'b0, din};
   assign at_top  = (q_ext == MAX_CNT);
   assign at_bot  = (q_ext == '0);
   assign tc      = en & (up_dn ? at_top : at_bot);

   assign load_val = (din_ext > MAX_CNT) ? MAX_Q : din;

   always_comb begin
      q_step = q;
`ifdef UPDN_CNT_SAT_EN
      if (tc)
         q_step = q;
      else if (up_dn)
         q_step = q + WIDTH'(1);
      else
         q_step = q - WIDTH'(1);
`else
      if (up_dn)
         q_step = at_top ? '0 : q + WIDTH'(1);
      else
         q_step = at_bot ? MAX_Q : q - WIDTH'(1);
`endif
   end

   // A limit hit (wrap or saturation hold) is exactly tc on an unloaded edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         wrap  <= 1'b0;
         dir_q <= 1'b1;
      end else if (load) begin
         q     <= load_val;
         wrap  <= 1'b0;
      end else if (en) begin
         q     <= q_step;
         wrap  <= tc;
         dir_q <= up_dn;
      end else begin
         wrap  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - directed bench for param_updown_counter (MOD=10 and MOD=16)
module tb_param_updown_counter;

   logic       clk = 1'b0;
   logic       rst, en, up_dn, load;
   logic [3:0] din;
   logic [3:0] q10, q16;
   logic       tc10, tc16, wrap10, wrap16, dir10, dir16;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   param_updown_counter #(.WIDTH(4), .MOD(10)) dut10 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din),
      .q(q10), .tc(tc10), .wrap(wrap10), .dir_q(dir10)
   );

   param_updown_counter #(.WIDTH(4), .MOD(16)) dut16 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din),
      .q(q16), .tc(tc16), .wrap(wrap16), .dir_q(dir16)
   );

   task automatic chk(input string tag, input int obs, input int exp_v);
      chk_cnt++;
      if (obs == exp_v)
         pass_cnt++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic l, input logic e, input logic u, input logic [3:0] d);
      rst = r; load = l; en = e; up_dn = u; din = d;
      #1;
   endtask

   initial begin
      drive(1, 1, 1, 1, 4'd5);
      tick();
      tick();
      chk("rst_q", q10, 0);
      chk("rst_wrap", wrap10, 0);
      chk("rst_dir", dir10, 1);

`ifndef UPDN_CNT_SAT_EN
      drive(0, 0, 1, 1, 4'd0);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("up_tc_%0d", i), tc10, (i % 10) == 9);
         tick();
         chk($sformatf("up_q_%0d", i), q10, (i + 1) % 10);
         chk($sformatf("up_wrap_%0d", i), wrap10, (i % 10) == 9);
      end

      drive(1, 0, 1, 1, 4'd0);
      tick();
      chk("midrst_q", q10, 0);
      chk("midrst_dir", dir10, 1);

      drive(0, 0, 1, 0, 4'd0);
      chk("dn_tc0", tc10, 1);
      tick();
      chk("dn_q9", q10, 9);
      chk("dn_wrap9", wrap10, 1);
      chk("dn_dir", dir10, 0);
      chk("dn_tc9", tc10, 0);
      tick();
      chk("dn_q8", q10, 8);
      chk("dn_wrap8", wrap10, 0);
      tick();
      chk("dn_q7", q10, 7);
      chk("dn_wrap7", wrap10, 0);

      drive(0, 0, 1, 1, 4'd0);
      tick();
      chk("dirchg_q", q10, 8);
      chk("dirchg_dir", dir10, 1);

      drive(0, 1, 0, 1, 4'd3);
      tick();
      chk("load3_q", q10, 3);
      drive(0, 0, 1, 0, 4'd0);
      tick();
      chk("dn_after_load_q", q10, 2);
      chk("dn_after_load_dir", dir10, 0);

      drive(0, 1, 1, 1, 4'd12);
      tick();
      chk("clamp_q", q10, 9);
      chk("clamp_wrap", wrap10, 0);
      chk("load_keeps_dir", dir10, 0);

      drive(0, 1, 1, 1, 4'd3);
      chk("load_tc", tc10, 1);
      tick();
      chk("load_over_tc_q", q10, 3);
      chk("load_over_tc_wrap", wrap10, 0);

      drive(0, 0, 0, 1, 4'd0);
      chk("hold_tc", tc10, 0);
      tick();
      tick();
      chk("hold_q", q10, 3);
      chk("hold_wrap", wrap10, 0);

      drive(0, 1, 0, 1, 4'd15);
      tick();
      chk("m16_load_q", q16, 15);
      chk("m10_load15_q", q10, 9);
      drive(0, 0, 1, 1, 4'd0);
      chk("m16_tc", tc16, 1);
      tick();
      chk("m16_wrap_q", q16, 0);
      chk("m16_wrap", wrap16, 1);
      chk("m10_wrap_q", q10, 0);
      tick();
      chk("m16_q1", q16, 1);
      chk("m16_wrap_clr", wrap16, 0);
`else
      drive(0, 1, 0, 1, 4'd8);
      tick();
      drive(0, 0, 1, 1, 4'd0);
      tick();
      chk("sat_q1", q10, 9);
      chk("sat_wrap1", wrap10, 0);
      chk("sat_tc", tc10, 1);
      tick();
      chk("sat_q2", q10, 9);
      chk("sat_wrap2", wrap10, 1);
      tick();
      chk("sat_q3", q10, 9);
      chk("sat_wrap3", wrap10, 1);
      drive(0, 0, 1, 0, 4'd0);
      tick();
      chk("sat_dn_q", q10, 8);
      chk("sat_dn_wrap", wrap10, 0);

      drive(0, 1, 0, 0, 4'd0);
      tick();
      drive(0, 0, 1, 0, 4'd0);
      tick();
      chk("sat_bot_q", q10, 0);
      chk("sat_bot_wrap", wrap10, 1);

      drive(0, 1, 0, 1, 4'd15);
      tick();
      drive(0, 0, 1, 1, 4'd0);
      tick();
      chk("sat16_q", q16, 15);
      chk("sat16_wrap", wrap16, 1);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
